mem_arbiter: RTL and testbench

//  Shares the single data RAM between instruction fetch (read-only) and the Memory stage (read/write).

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported data RAM between instruction fetch (read-only)
//   and the Memory stage (read/write). One access is in flight at a time:
//   IDLE (arbitrate + latch request) -> ACCESS (RAM_LATENCY cycles of ram_ce)
//   -> DONE (1-cycle ready pulse to the owner) -> IDLE.
//
// Parameters
//   RAM_LATENCY  cycles ram_ce is held per access (1..15)
//   MAX_STREAK   consecutive Memory-stage grants while fetch waits before
//                fetch is forced through (1..15)
//
// Ports
//   clock, reset                 clock; synchronous active-high reset
//   if_mc_en/if_mc_addr          fetch request (held until mc_if_ready)
//   mc_if_ready/mc_if_data       fetch completion pulse and read data
//   mem_mc_en/rw/addr/wdata      Memory-stage request (held until mc_mem_ready)
//   mc_mem_ready/mc_mem_rdata    Memory-stage completion pulse and read data
//   ram_ce/we/addr/wdata         RAM control, driven only during ACCESS
//   ram_rdata                    RAM read data, valid on the last ram_ce cycle
module mem_arbiter #(
  parameter int unsigned RAM_LATENCY = 2,
  parameter int unsigned MAX_STREAK  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_mc_en,
  input  logic [17:0] if_mc_addr,
  output logic        mc_if_ready,
  output logic [31:0] mc_if_data,
  input  logic        mem_mc_en,
  input  logic        mem_mc_rw,
  input  logic [17:0] mem_mc_addr,
  input  logic [31:0] mem_mc_wdata,
  output logic        mc_mem_ready,
  output logic [31:0] mc_mem_rdata,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [17:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM
  } owner_t;

  localparam logic [3:0] LP_LAST = 4'(RAM_LATENCY - 1);
  localparam logic [3:0] LP_MAX  = 4'(MAX_STREAK);

  state_t      r_state;
  state_t      w_next_state;
  owner_t      r_owner;
  logic [3:0]  r_cnt;
  logic [3:0]  r_streak;
  logic [3:0]  w_next_streak;
  logic [17:0] r_addr;
  logic        r_rw;
  logic [31:0] r_wdata;
  logic [31:0] r_if_data;
  logic [31:0] r_mem_data;
  logic        w_grant_if;
  logic        w_grant_mem;
  logic        w_last;

  // Next state, arbitration and outputs.
  always_comb begin
    w_next_state  = r_state;
    w_next_streak = r_streak;
    w_grant_if    = 1'b0;
    w_grant_mem   = 1'b0;
    w_last        = (r_cnt == LP_LAST);

    unique case (r_state)
      ST_IDLE: begin
        // Memory stage has priority unless fetch has already waited out
        // MAX_STREAK Memory grants.
        if (mem_mc_en && (!if_mc_en || (r_streak != LP_MAX))) begin
          w_grant_mem = 1'b1;
        end else if (if_mc_en) begin
          w_grant_if = 1'b1;
        end

        if (w_grant_mem) begin
          // Streak only counts Memory grants that actually made fetch wait.
          if (if_mc_en) begin
            w_next_streak = (r_streak == LP_MAX) ? LP_MAX : r_streak + 4'd1;
          end else begin
            w_next_streak = '0;
          end
        end else if (w_grant_if) begin
          w_next_streak = '0;
        end

        if (w_grant_if || w_grant_mem) begin
          w_next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (w_last) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    ram_ce       = (r_state == ST_ACCESS);
    ram_we       = ram_ce && r_rw;
    ram_addr     = ram_ce ? r_addr  : '0;
    ram_wdata    = ram_ce ? r_wdata : '0;
    mc_if_ready  = (r_state == ST_DONE) && (r_owner == OWN_IF);
    mc_mem_ready = (r_state == ST_DONE) && (r_owner == OWN_MEM);
    mc_if_data   = r_if_data;
    mc_mem_rdata = r_mem_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner    <= OWN_NONE;
      r_cnt      <= '0;
      r_streak   <= '0;
      r_addr     <= '0;
      r_rw       <= 1'b0;
      r_wdata    <= '0;
      r_if_data  <= '0;
      r_mem_data <= '0;
    end else begin
      r_streak <= w_next_streak;

      if (w_grant_if) begin
        r_owner <= OWN_IF;
        r_addr  <= if_mc_addr;
        r_rw    <= 1'b0;
        r_wdata <= '0;
        r_cnt   <= '0;
      end else if (w_grant_mem) begin
        r_owner <= OWN_MEM;
        r_addr  <= mem_mc_addr;
        r_rw    <= mem_mc_rw;
        r_wdata <= mem_mc_wdata;
        r_cnt   <= '0;
      end

      if (r_state == ST_ACCESS) begin
        r_cnt <= r_cnt + 4'd1;
        if (w_last) begin
          if (r_owner == OWN_IF) begin
            r_if_data <= ram_rdata;
          end else if (!r_rw) begin
            // Writes leave the last read value on mc_mem_rdata.
            r_mem_data <= ram_rdata;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int unsigned L  = 2;
  localparam int unsigned MS = 2;
  localparam int W_IF  = 1;
  localparam int W_MEM = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_mc_en;
  logic [17:0] if_mc_addr;
  logic        mc_if_ready;
  logic [31:0] mc_if_data;
  logic        mem_mc_en;
  logic        mem_mc_rw;
  logic [17:0] mem_mc_addr;
  logic [31:0] mem_mc_wdata;
  logic        mc_mem_ready;
  logic [31:0] mc_mem_rdata;
  logic        ram_ce;
  logic        ram_we;
  logic [17:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.RAM_LATENCY(L), .MAX_STREAK(MS)) dut (
    .clock(clk), .reset(reset),
    .if_mc_en(if_mc_en), .if_mc_addr(if_mc_addr),
    .mc_if_ready(mc_if_ready), .mc_if_data(mc_if_data),
    .mem_mc_en(mem_mc_en), .mem_mc_rw(mem_mc_rw),
    .mem_mc_addr(mem_mc_addr), .mem_mc_wdata(mem_mc_wdata),
    .mc_mem_ready(mc_mem_ready), .mc_mem_rdata(mc_mem_rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Contents of a never-written RAM word.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {24'h2A5C00, a};
  endfunction

  // RAM model: data only valid on the last ce cycle, junk otherwise.
  logic [31:0] ram_arr [256];
  bit          ram_wr  [256] = '{default: 1'b0};
  int unsigned ce_run = 0;

  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      ram_arr[ram_addr[7:0]] <= ram_wdata;
      ram_wr[ram_addr[7:0]]  <= 1'b1;
    end
    ce_run <= ram_ce ? ce_run + 1 : 0;
  end

  always @(negedge clk) begin
    if (ram_ce && ce_run == L - 1)
      ram_rdata <= ram_wr[ram_addr[7:0]] ? ram_arr[ram_addr[7:0]] : init_val(ram_addr[7:0]);
    else
      ram_rdata <= 32'hBAD00BAD;
  end

  // Reference model state
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          m_streak = 0;
  bit          p_if = 0, p_mem = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] m_if_data = '0;
  int          last_ready = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic req_if(input logic [17:0] a);
    if_mc_en = 1'b1; if_mc_addr = a; p_if = 1;
  endtask

  task automatic req_mem(input logic rw, input logic [17:0] a, input logic [31:0] d);
    mem_mc_en = 1'b1; mem_mc_rw = rw; mem_mc_addr = a; mem_mc_wdata = d; p_mem = 1;
  endtask

  task automatic chk_quiet(input string tag);
    chk1({tag, "_ce"}, ram_ce, 1'b0);
    chk1({tag, "_we"}, ram_we, 1'b0);
    chk1({tag, "_ifrdy"}, mc_if_ready, 1'b0);
    chk1({tag, "_memrdy"}, mc_mem_ready, 1'b0);
  endtask

  // One complete access, starting at an IDLE cycle with requests applied.
  task automatic run_txn(output int win);
    logic [17:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_data;
    if (p_mem && (!p_if || m_streak != int'(MS))) win = W_MEM;
    else win = W_IF;
    if (win == W_IF) m_streak = 0;
    else if (p_if) m_streak = (m_streak == int'(MS)) ? int'(MS) : m_streak + 1;
    else m_streak = 0;
    if (win == W_IF) begin
      e_addr = if_mc_addr; e_we = 1'b0; e_wdata = '0;
    end else begin
      e_addr = mem_mc_addr; e_we = mem_mc_rw; e_wdata = mem_mc_wdata;
    end
    e_data = ref_mem[e_addr[7:0]];
    for (int k = 1; k <= int'(L); k++) begin
      step();
      chk1("acc_ce", ram_ce, 1'b1);
      chk1("acc_we", ram_we, e_we);
      chk("acc_addr", {14'h0, ram_addr}, {14'h0, e_addr});
      if (e_we) chk("acc_wdata", ram_wdata, e_wdata);
      chk1("acc_ifrdy", mc_if_ready, 1'b0);
      chk1("acc_memrdy", mc_mem_ready, 1'b0);
      if (k == 1) begin
        // Winner's inputs change mid-access; must not affect it.
        if (win == W_IF) if_mc_addr = 18'($urandom);
        else begin
          mem_mc_addr = 18'($urandom); mem_mc_wdata = $urandom; mem_mc_rw = ~mem_mc_rw;
        end
      end
    end
    step();
    chk1("done_ifrdy", mc_if_ready, win == W_IF);
    chk1("done_memrdy", mc_mem_ready, win == W_MEM);
    chk1("done_ce", ram_ce, 1'b0);
    chk1("done_we", ram_we, 1'b0);
    if (win == W_IF) begin
      chk("if_data", mc_if_data, e_data);
      m_if_data = e_data;
    end else if (!e_we) begin
      chk("mem_rdata", mc_mem_rdata, e_data);
    end
    if (e_we) ref_mem[e_addr[7:0]] = e_wdata;
    last_ready = cyc;
    if (win == W_IF) begin if_mc_en = 1'b0; p_if = 0; end
    else begin mem_mc_en = 1'b0; p_mem = 0; end
    step();
    chk_quiet("idle");
    chk("if_data_hold", mc_if_data, m_if_data);
  endtask

  initial begin
    int w;
    int r1;
    int order [6];
    order = '{W_MEM, W_MEM, W_IF, W_MEM, W_MEM, W_IF};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    reset = 1'b1;
    if_mc_en = 1'b0; if_mc_addr = '0;
    mem_mc_en = 1'b0; mem_mc_rw = 1'b0; mem_mc_addr = '0; mem_mc_wdata = '0;

    // 1: reset with both requesting
    req_if(18'h00015);
    req_mem(1'b0, 18'h00030, 32'h0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk_quiet("rst");
      chk("rst_addr", {14'h0, ram_addr}, 32'h0);
      chk("rst_wdata", ram_wdata, 32'h0);
      chk("rst_ifdata", mc_if_data, 32'h0);
      chk("rst_memdata", mc_mem_rdata, 32'h0);
    end
    reset = 1'b0;
    m_streak = 0;
    run_txn(w); chk("rst_first_grant", w, W_MEM);
    run_txn(w); chk("rst_second_grant", w, W_IF);

    // 2: fetch read
    req_if(18'h00010);
    run_txn(w); chk("fetch_grant", w, W_IF);
    chk("fetch_data", m_if_data, 32'hDEADBEEF);

    // 3: write then read back
    req_mem(1'b1, 18'h0003F, 32'h12345678);
    run_txn(w); chk("wr_grant", w, W_MEM);
    r1 = last_ready;
    req_mem(1'b0, 18'h0003F, 32'h0);
    run_txn(w); chk("rd_grant", w, W_MEM);
    chk("wr_rd_spacing", last_ready - r1, L + 2);

    // 4: contention
    req_if(18'h00010);
    req_mem(1'b1, 18'h00041, 32'hA5A5F00D);
    run_txn(w); chk("cont_first", w, W_MEM);
    r1 = last_ready;
    run_txn(w); chk("cont_second", w, W_IF);
    chk("cont_spacing", last_ready - r1, L + 2);

    // 5: starvation guard
    for (int i = 0; i < 6; i++) begin
      if (!p_if) req_if(18'(64 + i));
      if (!p_mem) req_mem(1'b0, 18'(80 + i), 32'h0);
      run_txn(w);
      chk($sformatf("starve_%0d", i), w, order[i]);
    end
    run_txn(w); chk("starve_drain", w, W_MEM);

    // 6: reset during a write access
    req_mem(1'b1, 18'h00020, 32'hCAFEF00D);
    step();
    chk1("abort_ce_on", ram_ce, 1'b1);
    chk1("abort_we_on", ram_we, 1'b1);
    reset = 1'b1; mem_mc_en = 1'b0; p_mem = 0;
    step();
    chk_quiet("abort");
    chk("abort_ifdata", mc_if_data, 32'h0);
    reset = 1'b0; m_streak = 0; m_if_data = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_quiet("abort_idle");
    end
    req_if(18'h00010);
    run_txn(w); chk("abort_recover", w, W_IF);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      for (int tries = 0; tries < 20 && !p_if && !p_mem; tries++) begin
        if (!p_if && $urandom_range(0, 9) < 5) req_if(18'($urandom_range(64, 127)));
        if (!p_mem && $urandom_range(0, 9) < 6)
          req_mem(1'($urandom_range(0, 1)), 18'($urandom_range(64, 127)), $urandom);
        if (!p_if && !p_mem) begin
          step();
          chk_quiet("rand_idle");
        end
      end
      if (!p_if && !p_mem) req_mem(1'b0, 18'h00050, 32'h0);
      if (!p_if && $urandom_range(0, 3) == 0) req_if(18'($urandom_range(64, 127)));
      run_txn(w);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
